// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller wrapped around a simple dual-port RAM.
// Generates RAM write/read addresses and enables, hides the RAM's one-cycle
// read latency behind a registered output-valid flag, and exposes a
// ready/valid push/pop stream interface. Capacity is MEM_DEPTH words in RAM
// plus the one word parked on the RAM output.
module ram_fifo_ctrl #(
  parameter int MEM_WIDTH = 8,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = $clog2(MEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MEM_WIDTH-1:0] push_data,
  input  logic                 push_valid,
  output logic                 push_ready,
  output logic                 pop_valid,
  input  logic                 pop_ready,
  output logic [MEM_WIDTH-1:0] pop_data,
  output logic [ADDR_SIZE:0]   level,
  output logic                 overflow,
  output logic [MEM_WIDTH-1:0] ram_din,
  output logic [ADDR_SIZE-1:0] ram_addr_wr,
  output logic [ADDR_SIZE-1:0] ram_addr_rd,
  output logic                 ram_wr_en,
  output logic                 ram_rd_en,
  input  logic [MEM_WIDTH-1:0] ram_dout
);

  localparam int CW = ADDR_SIZE + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(MEM_DEPTH);

  logic [ADDR_SIZE-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_SIZE-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0]        memCount_q, memCount_d;
  logic                 outValid_q, outValid_d;
  logic                 overflow_q, overflow_d;

  logic full;
  logic pushFire;
  logic popFire;
  logic readFire;

  // Handshake decode: a read is launched whenever RAM holds data and the
  // output slot is free or being vacated this cycle. Only entries written on
  // an earlier edge are counted, so a read never targets the word being
  // written in the same cycle.
  always_comb begin
    full     = (memCount_q == DEPTH_CNT);
    pushFire = push_valid & ~full & ~rst;
    popFire  = outValid_q & pop_ready;
    readFire = ~rst & (memCount_q != '0) & (~outValid_q | popFire);
  end

  // Next-state computation for pointers, occupancy and the output-valid flag;
  // pointers wrap naturally because MEM_DEPTH is a power of two.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    memCount_d = memCount_q;
    outValid_d = outValid_q;
    overflow_d = push_valid & full;

    if (pushFire) begin
      wrPtr_d = wrPtr_q + ADDR_SIZE'(1);
    end
    if (readFire) begin
      rdPtr_d = rdPtr_q + ADDR_SIZE'(1);
    end

    case ({pushFire, readFire})
      2'b10:   memCount_d = memCount_q + CW'(1);
      2'b01:   memCount_d = memCount_q - CW'(1);
      default: memCount_d = memCount_q;
    endcase

    if (readFire) begin
      outValid_d = 1'b1;
    end else if (popFire) begin
      outValid_d = 1'b0;
    end
  end

  // State register with synchronous reset that discards all buffered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      memCount_q <= '0;
      outValid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      memCount_q <= memCount_d;
      outValid_q <= outValid_d;
      overflow_q <= overflow_d;
    end
  end

  // Output mapping: the head word lives on the RAM output and stays stable
  // while no read is issued.
  always_comb begin
    push_ready  = ~full & ~rst;
    pop_valid   = outValid_q;
    pop_data    = ram_dout;
    level       = memCount_q + CW'(outValid_q);
    overflow    = overflow_q;
    ram_din     = push_data;
    ram_addr_wr = wrPtr_q;
    ram_addr_rd = rdPtr_q;
    ram_wr_en   = pushFire;
    ram_rd_en   = readFire;
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: bench for ram_fifo_ctrl with a 4-deep behavioural RAM.
// A queue-based reference model is compared against the DUT every cycle,
// and directed scenarios add hand-computed literal expectations.
module tb_ram_fifo_ctrl;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  push_data = '0;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic          pop_valid;
  logic          pop_ready = 1'b0;
  logic [W-1:0]  pop_data;
  logic [AW:0]   level;
  logic          overflow;
  logic [W-1:0]  ram_din;
  logic [AW-1:0] ram_addr_wr;
  logic [AW-1:0] ram_addr_rd;
  logic          ram_wr_en;
  logic          ram_rd_en;
  logic [W-1:0]  ram_dout = '0;

  int compareCount  = 0;
  int mismatchCount = 0;

  ram_fifo_ctrl #(
    .MEM_WIDTH (W),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push_data   (push_data),
    .push_valid  (push_valid),
    .push_ready  (push_ready),
    .pop_valid   (pop_valid),
    .pop_ready   (pop_ready),
    .pop_data    (pop_data),
    .level       (level),
    .overflow    (overflow),
    .ram_din     (ram_din),
    .ram_addr_wr (ram_addr_wr),
    .ram_addr_rd (ram_addr_rd),
    .ram_wr_en   (ram_wr_en),
    .ram_rd_en   (ram_rd_en),
    .ram_dout    (ram_dout)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Simple dual-port RAM with one-cycle registered read.
  logic [W-1:0] ramArray [DEPTH];
  always @(posedge clk) begin
    if (ram_wr_en) ramArray[ram_addr_wr] <= ram_din;
    if (ram_rd_en) ram_dout <= ramArray[ram_addr_rd];
  end

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs; returns 1 time unit after the edge that used them.
  task automatic applyStimulus(input logic pushV, input logic [W-1:0] data,
                               input logic popR, input logic rstV);
    push_valid = pushV;
    push_data  = data;
    pop_ready  = popR;
    rst        = rstV;
    @(posedge clk);
    #1;
  endtask

  // Reference model: words held in RAM as a queue, plus the head word slot.
  byte unsigned modelQ[$];
  byte unsigned headWord   = 0;
  bit           headValid  = 0;
  bit           ovfExp     = 0;
  bit           modelLive  = 0;

  // Advance the model on every edge from the inputs present before it.
  always @(posedge clk) begin
    bit mFull, pushAcc, popAcc, readNow;
    if (rst) begin
      modelQ.delete();
      headValid = 0;
      ovfExp    = 0;
      modelLive = 1;
    end else begin
      mFull   = (modelQ.size() == DEPTH);
      pushAcc = push_valid && !mFull;
      popAcc  = headValid && pop_ready;
      readNow = (modelQ.size() != 0) && (!headValid || popAcc);
      ovfExp  = push_valid && mFull;
      if (readNow) begin
        headWord  = modelQ.pop_front();
        headValid = 1;
      end else if (popAcc) begin
        headValid = 0;
      end
      if (pushAcc) modelQ.push_back(push_data);
    end
  end

  // Per-cycle compare on the falling edge, plus a log of consumed words.
  byte unsigned popLog[$];
  always @(negedge clk) begin
    bit expFull, expPushReady;
    if (modelLive) begin
      expFull      = (modelQ.size() == DEPTH);
      expPushReady = !rst && !expFull;
      checkOutput("push_ready", 32'(push_ready), 32'(expPushReady));
      checkOutput("pop_valid", 32'(pop_valid), 32'(headValid));
      checkOutput("level", 32'(level), 32'(modelQ.size() + int'(headValid)));
      checkOutput("overflow", 32'(overflow), 32'(ovfExp));
      checkOutput("ram_wr_en", 32'(ram_wr_en), 32'(push_valid && expPushReady));
      checkOutput("ram_rd_en", 32'(ram_rd_en),
                  32'(!rst && modelQ.size() != 0 && (!headValid || pop_ready)));
      if (headValid) checkOutput("pop_data", 32'(pop_data), 32'(headWord));
      if (!rst && pop_valid && pop_ready) popLog.push_back(pop_data);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with literal expectations.
  initial begin
    // Reset
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    rst = 1'b0;
    #1;
    checkOutput("reset level", 32'(level), 32'd0);
    checkOutput("reset pop_valid", 32'(pop_valid), 32'd0);
    checkOutput("reset push_ready", 32'(push_ready), 32'd1);

    // Single word, two-cycle latency
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    checkOutput("t1 pop_valid after 1 edge", 32'(pop_valid), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t1 pop_valid", 32'(pop_valid), 32'd1);
    checkOutput("t1 pop_data", 32'(pop_data), 32'h11);
    checkOutput("t1 level", 32'(level), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("t1 level after pop", 32'(level), 32'd0);
    checkOutput("t1 pop_valid after pop", 32'(pop_valid), 32'd0);

    // Fill to capacity, overflow, drain in order
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    checkOutput("t2 level full", 32'(level), 32'd5);
    checkOutput("t2 push_ready full", 32'(push_ready), 32'd0);
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    checkOutput("t2 overflow pulse", 32'(overflow), 32'd1);
    checkOutput("t2 level after overflow", 32'(level), 32'd5);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t2 overflow clears", 32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t2 drain pop_data", 32'(pop_data), 32'(8'hA0 + i));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("t2 level drained", 32'(level), 32'd0);

    // Streaming 20 words with pointer wrap
    popLog.delete();
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("t3 popped count", 32'(popLog.size()), 32'd20);
    for (int i = 0; i < popLog.size(); i++)
      checkOutput("t3 stream order", 32'(popLog[i]), 32'(i));
    checkOutput("t3 wr pointer", 32'(ram_addr_wr), 32'd2);
    checkOutput("t3 rd pointer", 32'(ram_addr_rd), 32'd2);

    // Stalled head while pushing
    applyStimulus(1'b1, 8'h31, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h32, 1'b0, 1'b0);
    checkOutput("t4 pop_valid", 32'(pop_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 8'(8'h33 + k), 1'b0, 1'b0);
      checkOutput("t4 stalled pop_data", 32'(pop_data), 32'h31);
      checkOutput("t4 stalled ram_rd_en", 32'(ram_rd_en), 32'd0);
    end
    for (int k = 0; k < 5; k++) begin
      checkOutput("t4 drain pop_data", 32'(pop_data), 32'(8'h31 + k));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Reset in the middle of pushing
    applyStimulus(1'b1, 8'h41, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h42, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h43, 1'b0, 1'b0);
    checkOutput("t5 level before reset", 32'(level), 32'd3);
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b1);
    rst        = 1'b0;
    push_valid = 1'b0;
    #1;
    checkOutput("t5 level after reset", 32'(level), 32'd0);
    checkOutput("t5 pop_valid after reset", 32'(pop_valid), 32'd0);
    checkOutput("t5 push_ready after reset", 32'(push_ready), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t5 pop_valid", 32'(pop_valid), 32'd1);
    checkOutput("t5 pop_data", 32'(pop_data), 32'h5A);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
    checkOutput("t6 level full", 32'(level), 32'd5);
    applyStimulus(1'b1, 8'hB5, 1'b1, 1'b0);
    checkOutput("t6 overflow", 32'(overflow), 32'd1);
    checkOutput("t6 push_ready reopens", 32'(push_ready), 32'd1);
    checkOutput("t6 level after pop", 32'(level), 32'd4);
    applyStimulus(1'b1, 8'hB5, 1'b0, 1'b0);
    checkOutput("t6 level refilled", 32'(level), 32'd5);
    checkOutput("t6 overflow clears", 32'(overflow), 32'd0);
    for (int k = 0; k < 5; k++) begin
      checkOutput("t6 drain pop_data", 32'(pop_data), 32'(8'hB1 + k));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("t6 level drained", 32'(level), 32'd0);

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
